execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  EX stage of the 19-bit five-stage pipeline, directly upstream of the Memory stage: it owns the EX/MEM register driving *M signals.
//  Selects forwarded operands, runs the ALU, resolves branch/jump and computes the PC target.
//  Multiply is done by an iterative shift-add unit that stalls the front end through BusyE.
// PARAMETERS
//  DATA_W  19  datapath width (data, immediates, PC)
//  REG_W   5   register-address width
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low
//  RegWriteE, MemWriteE, ResultSrcE, Cant_ByteE, ALUSrcE, BranchE, JumpE  in 1 each  ID/EX controls
//  ALUControlE  in   4       ALU op (exec_pkg::alu_op_e)
//  RD1E, RD2E   in   DATA_W  register-file operands
//  ImmExtE, PCE in   DATA_W  extended immediate, PC of instruction
//  RdE          in   REG_W   destination register
//  ForwardAE, ForwardBE  in 2  00=RD*E, 01=ResultW, 10=ALUResultM (own register)
//  ResultW      in   DATA_W  writeback-stage result
//  RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM  out 1 each  EX/MEM controls
//  RDM          out  REG_W   EX/MEM destination
//  ALUResultM, WriteDataM  out DATA_W  EX/MEM result, store data (forwarded B)
//  PCSrcE       out  1       taken branch/jump (combinational)
//  PCTargetE    out  DATA_W  PCE + ImmExtE, mod 2^DATA_W
//  BusyE        out  1       hold IF/ID/ID-EX; combinational
// BEHAVIOUR
//  Reset (async, reset==0): all EX/MEM outputs 0, FSM IDLE, counter 0; a multiply in flight is abandoned.
//  SrcA = fwd(ForwardAE); fwdB = fwd(ForwardBE); SrcB = ALUSrcE ? ImmExtE : fwdB; 11 treated as 00.
//  ALU ops, all results mod 2^DATA_W: ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SLT7 (signed, 1/0) MUL8; codes 9-15 give 0.
//  Shifts use SrcB[4:0]; amount >= DATA_W gives 0.
//  Zero = (SrcA-SrcB == 0); PCSrcE = JumpE | (BranchE & Zero); PCSrcE forced 0 while FSM != IDLE.
//  Non-MUL op: 1-cycle latency; EX/MEM captures controls, RdE, ALU result, fwdB on each edge.
//  FSM states IDLE -> MBUSY -> MDONE -> IDLE:
//   IDLE, op==MUL: latch SrcA/SrcB, acc=0, cnt=0, go MBUSY; BusyE=1; EX/MEM loads bubble (all controls 0, RDM=0).
//   MBUSY: each cycle acc += mcand if mplier[0]; mcand<<=1, mplier>>=1, cnt++; BusyE=1; bubble into EX/MEM.
//   MBUSY exit: after DATA_W iterations (cnt==DATA_W-1) go MDONE.
//   MDONE: BusyE=0; EX/MEM captures ID/EX controls (held stable), RdE, acc[DATA_W-1:0]; go IDLE.
//   MUL total latency = DATA_W+2 cycles (21 at default), DATA_W+1 bubbles.
//  Upstream holds ID/EX inputs constant while BusyE=1; forwarding-input changes after issue are ignored (operands latched).
//  Back-to-back MUL: MDONE -> IDLE, then the next MUL issues on the following cycle.
//  Signed overflow on ADD/SUB/MUL wraps silently; no exception.
// STRUCTURE
//  exec_pkg: DATA_W/REG_W localparams, alu_op_e enum, fwd_sel_e (FWD_RF/FWD_W/FWD_M), mul_state_e.
//  Sub-module iter_mul (FSM + counter + acc, start/busy/done/product); ALU, forward muxes and EX/MEM register stay in execute_stage.
// TESTING
//  1. reset=0 mid-MBUSY (cnt=7) -> next edge: all *M = 0, BusyE=0, PCSrcE=0; after release an ADD issues normally.
//  2. ADD RD1E=19'h7FFFF, ImmExtE=1, ALUSrcE=1 -> ALUResultM=0 one cycle later; SUB 5-7 -> 19'h7FFFE; SLT -> 1.
//  3. ForwardAE=10, ALUResultM=12 from previous ADD, ForwardBE=01, ResultW=30 -> next ALUResultM=42, WriteDataM=30.
//  4. MUL 300*500 -> BusyE high 20 cycles, 20 bubbles (RegWriteM=0); cycle 21 ALUResultM=150000 mod 2^19=19'h249F0 (150000).
//  5. BEQ equal operands, PCE=100, ImmExtE=-4 -> PCSrcE=1, PCTargetE=96; unequal -> PCSrcE=0; JumpE=1 -> PCSrcE=1.
//  6. SLL by SrcB=19 -> 0; SRL 19'h40000 by 18 -> 1; ALUControlE=12 -> 0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and widths for the execute stage of the 19-bit pipeline.
package exec_pkg;

    localparam int DATA_W = 19;
    localparam int REG_W  = 5;
    localparam int CNT_W  = $clog2(DATA_W);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SLT = 4'd7,
        ALU_MUL = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_e;

endpackage

// File: rtl/execute_stage_iter_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, result mod 2^DATA_W.
module iter_mul
    import exec_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              idle,
    output logic [DATA_W-1:0] product
);

    mul_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= MUL_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1)) state <= MUL_DONE;
                end
                MUL_DONE: state <= MUL_IDLE;
                default:  state <= MUL_IDLE;
            endcase
        end
    end

    // busy covers the issue cycle too, so the front end stalls immediately.
    assign idle    = (state == MUL_IDLE);
    assign busy    = (idle && start) || (state == MUL_BUSY);
    assign done    = (state == MUL_DONE);
    assign product = acc;

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU, branch resolution, PC target and the EX/MEM register.
module execute_stage
    import exec_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              ResultSrcE,
    input  logic              Cant_ByteE,
    input  logic              ALUSrcE,
    input  logic              BranchE,
    input  logic              JumpE,
    input  logic [3:0]        ALUControlE,
    input  logic [DATA_W-1:0] RD1E,
    input  logic [DATA_W-1:0] RD2E,
    input  logic [DATA_W-1:0] ImmExtE,
    input  logic [DATA_W-1:0] PCE,
    input  logic [REG_W-1:0]  RdE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [DATA_W-1:0] ResultW,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              ResultSrcM,
    output logic              Cant_ByteM,
    output logic [REG_W-1:0]  RDM,
    output logic [DATA_W-1:0] ALUResultM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic              PCSrcE,
    output logic [DATA_W-1:0] PCTargetE,
    output logic              BusyE
);

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] alu_result;
    logic [4:0]        shamt;
    logic              zero;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic              mul_idle;
    logic [DATA_W-1:0] mul_product;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        src_a = RD1E;
        fwd_b = RD2E;
        case (ForwardAE)
            FWD_W:   src_a = ResultW;
            FWD_M:   src_a = ALUResultM;
            default: src_a = RD1E;
        endcase
        case (ForwardBE)
            FWD_W:   fwd_b = ResultW;
            FWD_M:   fwd_b = ALUResultM;
            default: fwd_b = RD2E;
        endcase
    end

    assign src_b = ALUSrcE ? ImmExtE : fwd_b;
    assign shamt = src_b[4:0];

    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SLL: alu_result = (shamt >= 5'(DATA_W)) ? '0 : src_a << shamt;
            ALU_SRL: alu_result = (shamt >= 5'(DATA_W)) ? '0 : src_a >> shamt;
            ALU_SLT: alu_result = DATA_W'($signed(src_a) < $signed(src_b));
            default: alu_result = '0;
        endcase
    end

    assign mul_start = (ALUControlE == ALU_MUL);

    iter_mul u_iter_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (src_a),
        .b       (src_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .idle    (mul_idle),
        .product (mul_product)
    );

    assign zero      = (src_a == src_b);
    assign PCSrcE    = mul_idle && (JumpE || (BranchE && zero));
    assign PCTargetE = PCE + ImmExtE;
    assign BusyE     = mul_busy;

    // While the multiplier runs, a bubble enters MEM; its completion cycle carries the product.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            Cant_ByteM <= 1'b0;
            RDM        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
        end else if (mul_busy) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            Cant_ByteM <= 1'b0;
            RDM        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            Cant_ByteM <= Cant_ByteE;
            RDM        <= RdE;
            ALUResultM <= mul_done ? mul_product : alu_result;
            WriteDataM <= fwd_b;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: arithmetic reference model plus directed literal checks.
module tb_execute_stage;

    localparam int  DW  = 19;
    localparam longint MOD = 524288;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, MemWriteE, ResultSrcE, Cant_ByteE, ALUSrcE, BranchE, JumpE;
    logic [3:0]  ALUControlE;
    logic [18:0] RD1E, RD2E, ImmExtE, PCE, ResultW;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM, PCSrcE, BusyE;
    logic [4:0]  RDM;
    logic [18:0] ALUResultM, WriteDataM, PCTargetE;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .Cant_ByteE(Cant_ByteE), .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .Cant_ByteM(Cant_ByteM), .RDM(RDM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: what the EX/MEM register must hold, plus a MUL countdown.
    logic        m_rw, m_mw, m_rs, m_cb, m_bubble, m_busy;
    logic [4:0]  m_rd;
    longint      m_alu, m_wd, mul_a, mul_b;
    int          mul_left;

    task automatic check(input string name, input longint act, input longint exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint fwd(input logic [1:0] sel, input longint rf);
        if (sel == 2'b01) return longint'(ResultW);
        if (sel == 2'b10) return m_alu;
        return rf;
    endfunction

    function automatic longint to_signed(input longint v);
        return (v >= MOD / 2) ? v - MOD : v;
    endfunction

    function automatic longint model_alu(input int op, input longint a, input longint b);
        longint sh;
        sh = b % 32;
        case (op)
            0: return (a + b) % MOD;
            1: return (a - b + MOD) % MOD;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (sh >= DW) ? 0 : (a * (longint'(1) << sh)) % MOD;
            6: return (sh >= DW) ? 0 : a / (longint'(1) << sh);
            7: return (to_signed(a) < to_signed(b)) ? 1 : 0;
            8: return (a * b) % MOD;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_rw = 0; m_mw = 0; m_rs = 0; m_cb = 0; m_rd = 0;
        m_alu = 0; m_wd = 0; m_bubble = 0; m_busy = 0; mul_left = 0;
    endtask

    task automatic drive_idle();
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; Cant_ByteE = 0;
        ALUSrcE = 0; BranchE = 0; JumpE = 0; ALUControlE = 4'd0;
        RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; RdE = 0;
        ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    // One clock cycle: check combinational outputs, advance model, check EX/MEM after the edge.
    task automatic step();
        longint sa, fb, sb, tgt;
        logic   e_busy, e_pc;
        #2;
        sa  = fwd(ForwardAE, longint'(RD1E));
        fb  = fwd(ForwardBE, longint'(RD2E));
        sb  = ALUSrcE ? longint'(ImmExtE) : fb;
        tgt = (longint'(PCE) + longint'(ImmExtE)) % MOD;
        e_busy = (mul_left == 0 && ALUControlE == 4'd8) || (mul_left > 1);
        e_pc   = (mul_left == 0) && (JumpE || (BranchE && sa == sb));
        check("BusyE", BusyE, e_busy);
        check("PCSrcE", PCSrcE, e_pc);
        check("PCTargetE", PCTargetE, tgt);
        m_busy = e_busy;
        if (mul_left == 0 && ALUControlE == 4'd8) begin
            mul_a = sa; mul_b = sb; mul_left = DW + 1; m_bubble = 1;
        end else if (mul_left > 1) begin
            mul_left--; m_bubble = 1;
        end else begin
            m_alu = (mul_left == 1) ? model_alu(8, mul_a, mul_b)
                                    : model_alu(int'(ALUControlE), sa, sb);
            mul_left = 0; m_bubble = 0;
            m_wd = fb;
        end
        if (m_bubble) begin
            m_rw = 0; m_mw = 0; m_rs = 0; m_cb = 0; m_rd = 0;
        end else begin
            m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE; m_cb = Cant_ByteE; m_rd = RdE;
        end
        @(posedge clk);
        #1;
        vectors++;
        check("RegWriteM", RegWriteM, m_rw);
        check("MemWriteM", MemWriteM, m_mw);
        check("ResultSrcM", ResultSrcM, m_rs);
        check("Cant_ByteM", Cant_ByteM, m_cb);
        check("RDM", RDM, m_rd);
        if (!m_bubble) begin
            check("ALUResultM", ALUResultM, m_alu);
            check("WriteDataM", WriteDataM, m_wd);
        end
    endtask

    function automatic logic [18:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 19'h00000;
            1: return 19'h00001;
            2: return 19'h7FFFF;
            3: return 19'h40000;
            default: return 19'($urandom);
        endcase
    endfunction

    initial begin
        int busy_cnt, bubble_cnt;
        drive_idle();
        model_reset();
        reset = 0;
        #23;
        check("reset_ALUResultM", ALUResultM, 0);
        check("reset_RegWriteM", RegWriteM, 0);
        check("reset_BusyE", BusyE, 0);
        reset = 1;
        @(posedge clk); #1;

        // ADD wrap, SUB underflow, SLT signed
        ALUControlE = 4'd0; RD1E = 19'h7FFFF; ImmExtE = 19'd1; ALUSrcE = 1; RegWriteE = 1; RdE = 5'd3;
        step(); check("add_wrap", ALUResultM, 0);
        ALUControlE = 4'd1; RD1E = 19'd5; RD2E = 19'd7; ALUSrcE = 0;
        step(); check("sub_neg", ALUResultM, 19'h7FFFE);
        ALUControlE = 4'd7;
        step(); check("slt", ALUResultM, 1);

        // Forwarding from MEM and WB
        ALUControlE = 4'd0; RD1E = 19'd5; ImmExtE = 19'd7; ALUSrcE = 1;
        step(); check("fwd_setup", ALUResultM, 12);
        ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 19'd30; ALUSrcE = 0; RD1E = 19'd999; RD2E = 19'd888;
        step(); check("fwd_alu", ALUResultM, 42); check("fwd_wd", WriteDataM, 30);
        ForwardAE = 0; ForwardBE = 0;

        // MUL 300*500: 20 busy cycles, 20 bubbles, product on cycle 21
        ALUControlE = 4'd8; RD1E = 19'd300; RD2E = 19'd500; ALUSrcE = 0; RegWriteE = 1; RdE = 5'd9;
        busy_cnt = 0; bubble_cnt = 0;
        for (int i = 0; i < 21; i++) begin
            #1;
            if (BusyE) busy_cnt++;
            step();
            if (!RegWriteM) bubble_cnt++;
        end
        check("mul_busy_cycles", busy_cnt, 20);
        check("mul_bubbles", bubble_cnt, 20);
        check("mul_result", ALUResultM, 150000);
        check("mul_rd", RDM, 9);

        // Branch / jump
        ALUControlE = 4'd1; RD1E = 19'd44; RD2E = 19'd44; BranchE = 1; PCE = 19'd100; ImmExtE = 19'h7FFFC;
        #1; check("beq_taken", PCSrcE, 1); check("pc_target", PCTargetE, 96);
        step();
        RD2E = 19'd45;
        #1; check("beq_not_taken", PCSrcE, 0);
        step();
        BranchE = 0; JumpE = 1;
        #1; check("jump", PCSrcE, 1);
        step();
        JumpE = 0;

        // Shift boundaries and unused opcode
        ALUControlE = 4'd5; RD1E = 19'd1; ImmExtE = 19'd19; ALUSrcE = 1;
        step(); check("sll_19", ALUResultM, 0);
        ALUControlE = 4'd6; RD1E = 19'h40000; ImmExtE = 19'd18;
        step(); check("srl_18", ALUResultM, 1);
        ALUControlE = 4'd12; RD1E = 19'd77;
        step(); check("op12", ALUResultM, 0);

        // Reset during MBUSY with cnt=7
        ALUControlE = 4'd8; RD1E = 19'd123; RD2E = 19'd456; ALUSrcE = 0;
        for (int i = 0; i < 8; i++) step();
        ALUControlE = 4'd0; RegWriteE = 1;
        reset = 0;
        #1;
        check("rst_mid_RegWriteM", RegWriteM, 0);
        check("rst_mid_RDM", RDM, 0);
        check("rst_mid_ALUResultM", ALUResultM, 0);
        check("rst_mid_WriteDataM", WriteDataM, 0);
        check("rst_mid_BusyE", BusyE, 0);
        check("rst_mid_PCSrcE", PCSrcE, 0);
        @(posedge clk); #3;
        check("rst_hold_ALUResultM", ALUResultM, 0);
        reset = 1;
        model_reset();
        RD1E = 19'd10; RD2E = 19'd20; RdE = 5'd4;
        step(); check("post_rst_add", ALUResultM, 30);

        // Randomized run; inputs held while the model says the stage is busy
        for (int n = 0; n < 600; n++) begin
            if (!m_busy) begin
                RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
                ResultSrcE = 1'($urandom); Cant_ByteE = 1'($urandom);
                ALUSrcE = 1'($urandom); BranchE = 1'($urandom); JumpE = ($urandom_range(0, 7) == 0);
                ALUControlE = 4'($urandom_range(0, 15));
                RD1E = pick_operand(); RD2E = pick_operand();
                ImmExtE = ($urandom_range(0, 2) == 0) ? 19'($urandom_range(0, 31)) : pick_operand();
                PCE = pick_operand(); RdE = 5'($urandom); ResultW = pick_operand();
                ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
                if (ALUControlE == 4'd8 && ForwardBE == 2'b10) ForwardBE = 2'b01;
                if ($urandom_range(0, 3) == 0) RD2E = RD1E;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
